loop_controller: RTL and testbench
==================================

Name: loop_controller

Overview:
- Sequences the program counter for bracket instructions (`[`, `]`) in the Brainfuck core.
- Sits between instruction decode and the PC counter, alongside the execute stage.
- Keeps a return-address stack of open-bracket PCs, drives the counter's `load`/`d` inputs for backward jumps and requests a pipeline flush.
- Runs a nesting-depth skip mode for forward jumps over zero-valued loops.

Parameters:
IA_WIDTH, 12, instruction address width; matches the PC counter.
DEPTH_LOG2, 4, log2 of the return-stack depth (16 entries).
SKIP_WIDTH, 8, width of the skip-mode nesting counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  decoded instruction presented
op_ready  output  1  controller accepts the instruction this cycle
op_open  input  1  instruction is `[`
op_close  input  1  instruction is `]`
op_pc  input  IA_WIDTH  address of the presented instruction
cell_zero  input  1  current data cell == 0; valid with op_valid
skip  output  1  high while in SKIP; downstream treats accepted non-bracket ops as NOP
pc_load  output  1  one-cycle load strobe to the PC counter
pc_d  output  IA_WIDTH  PC load value
flush  output  1  one-cycle pipeline flush request, coincident with pc_load
flush_done  input  1  pipeline has drained and refetch has started
depth  output  DEPTH_LOG2+1  return-stack occupancy, 0..2^DEPTH_LOG2
err_overflow  output  1  sticky: push to a full stack, or skip counter overflow
err_underflow  output  1  sticky: `]` executed with an empty stack

Behaviour:
- Reset (reset==0, asynchronous) values:
  - state=IDLE, depth=0, skip counter=0.
  - pc_load=0, pc_d=0, flush=0, err_*=0.
  - Stack contents are don't-care.
  - Reset mid-operation aborts any SKIP/WAIT_FLUSH state immediately.
- Transfer rule: transfer occurs on a rising edge when op_valid && op_ready.
  - op_ready = (state==IDLE || state==SKIP); combinational from state only.
- op_open && op_close together: illegal. The op is accepted as a non-bracket op with no state change.
- States: IDLE, SKIP, WAIT_FLUSH, ERROR.
- IDLE, transfer:
  - `[` && !cell_zero: push op_pc; depth+1. If depth == 2^DEPTH_LOG2, set err_overflow and go to ERROR (no push).
  - `[` && cell_zero: skip counter := 1; go to SKIP.
  - `]` && cell_zero: pop; depth-1. If depth==0, set err_underflow and go to ERROR.
  - `]` && !cell_zero:
    - If depth==0: set err_underflow, go to ERROR.
    - Otherwise pc_d := top+1 (mod 2^IA_WIDTH wrap), pc_load=1 and flush=1 for exactly the next cycle, go to WAIT_FLUSH.
    - The stack is not popped.
  - Other ops: no effect.
- SKIP, transfer (skip==1 throughout):
  - `[`: counter+1. If the counter is already all-ones, set err_overflow and go to ERROR.
  - `]`: counter-1. On reaching 0, go to IDLE; that `]` is consumed and not executed.
  - cell_zero is ignored in SKIP.
- WAIT_FLUSH:
  - op_ready=0.
  - pc_load/flush are high only on the first cycle.
  - flush_done is sampled from the first WAIT_FLUSH cycle onward, including the strobe cycle; go to IDLE on the same edge that sees flush_done=1.
  - Minimum jump penalty is 1 cycle plus the pipeline drain time.
- ERROR: op_ready=0, skip=0. Held until reset; error flags remain set.
- depth is registered and updates on the edge after a push or pop.
- Stack memory is written only on push; top = entry[depth-1].

Decomposition:
- Constants.v gains:
  - state encodings LC_IDLE, LC_SKIP, LC_WAIT_FLUSH, LC_ERROR (2-bit);
  - `LC_STATE_MSB.
- One sub-module, loop_stack: a parameterised LIFO with push/pop/top/depth and full/empty flags, and no error logic.
- loop_controller owns the FSM, skip counter, error flags and PC/flush outputs.

Test Plan:
1. Present `[`@0x010 with cell_zero=0 -> depth 1. Then `]`@0x015 with cell_zero=0 -> next cycle pc_load=1, pc_d=0x011, flush=1 for one cycle, op_ready=0. Assert flush_done 3 cycles later -> IDLE, depth still 1.
2. Continue from 1: `]`@0x015 with cell_zero=1 -> depth 0, no pc_load.
3. `[` with cell_zero=1, then `+ [ - ] . ]` -> skip=1 through all six ops; counter goes 1,2,1,0; skip=0 after the final `]`; depth unchanged.
4. 16 pushes with cell_zero=0, then a 17th `[` -> err_overflow=1, state ERROR, op_ready=0. Only reset clears it.
5. `]` with depth 0 -> err_underflow=1, ERROR, no pc_load.
6. Drive reset low asynchronously mid-SKIP and mid-WAIT_FLUSH -> all outputs return to reset values without a clock edge. After release, `[`@0xFFF pushed, then `]` nonzero -> pc_d=0x000 (wrap).

Source files
------------

// File: rtl/loop_controller_pkg.sv
// rtl/loop_controller_pkg.sv - shared state encoding and defaults for the loop controller
package loop_controller_pkg;

    typedef enum logic [1:0] {
        LC_IDLE       = 2'd0,
        LC_SKIP       = 2'd1,
        LC_WAIT_FLUSH = 2'd2,
        LC_ERROR      = 2'd3
    } lc_state_e;

    localparam int LC_STATE_MSB       = 1;
    localparam int LC_IA_WIDTH_DEF    = 12;
    localparam int LC_DEPTH_LOG2_DEF  = 4;
    localparam int LC_SKIP_WIDTH_DEF  = 8;

endpackage

// File: rtl/loop_controller_if.sv
// rtl/loop_controller_if.sv - decoded-instruction handshake between decode and the loop controller
interface loop_controller_if #(
    parameter int IA_WIDTH = 12
);
    logic                op_valid;
    logic                op_ready;
    logic                op_open;
    logic                op_close;
    logic [IA_WIDTH-1:0] op_pc;
    logic                cell_zero;

    modport master (output op_valid, op_open, op_close, op_pc, cell_zero, input op_ready);
    modport slave  (input op_valid, op_open, op_close, op_pc, cell_zero, output op_ready);
endinterface

// File: rtl/loop_controller_stack.sv
// rtl/loop_controller_stack.sv - return-address LIFO holding open-bracket PCs
module loop_stack #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      push_data_i,
    output logic [WIDTH-1:0]      top_o,
    output logic [DEPTH_LOG2:0]   depth_o,
    output logic                  full_o,
    output logic                  empty_o
);
    logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0]   depth_q;
    logic [DEPTH_LOG2-1:0] top_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q <= '0;
        end else if (push_i) begin
            depth_q <= depth_q + 1'b1;
        end else if (pop_i) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[depth_q[DEPTH_LOG2-1:0]] <= push_data_i;
        end
    end

    assign top_idx = depth_q[DEPTH_LOG2-1:0] - {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    assign top_o   = mem_q[top_idx];
    assign depth_o = depth_q;
    assign full_o  = depth_q[DEPTH_LOG2];
    assign empty_o = (depth_q == '0);

endmodule

// File: rtl/loop_controller.sv
// rtl/loop_controller.sv - bracket sequencing: return stack, backward jumps with flush, forward skip mode
module loop_controller
    import loop_controller_pkg::*;
#(
    parameter int IA_WIDTH   = LC_IA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = LC_DEPTH_LOG2_DEF,
    parameter int SKIP_WIDTH = LC_SKIP_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    loop_controller_if.slave    op_if,
    output logic                skip,
    output logic                pc_load,
    output logic [IA_WIDTH-1:0] pc_d,
    output logic                flush,
    input  logic                flush_done,
    output logic [DEPTH_LOG2:0] depth,
    output logic                err_overflow,
    output logic                err_underflow
);
    lc_state_e             state_q, state_d;
    logic [SKIP_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
    logic                  pc_load_q, pc_load_d;
    logic [IA_WIDTH-1:0]   pc_d_q, pc_d_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  push, pop, full, empty, xfer, is_open, is_close;
    logic [IA_WIDTH-1:0]   top;

    loop_stack #(
        .WIDTH      (IA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (op_if.op_pc),
        .top_o       (top),
        .depth_o     (depth),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign op_if.op_ready = (state_q == LC_IDLE) || (state_q == LC_SKIP);
    assign xfer           = op_if.op_valid && op_if.op_ready;
    // Both bracket flags together degrade to a plain non-bracket op.
    assign is_open        = op_if.op_open && !op_if.op_close;
    assign is_close       = op_if.op_close && !op_if.op_open;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LC_IDLE;
            skip_cnt_q <= '0;
            pc_load_q  <= 1'b0;
            pc_d_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            pc_load_q  <= pc_load_d;
            pc_d_q     <= pc_d_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        pc_load_d  = 1'b0;
        pc_d_d     = pc_d_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push       = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            LC_IDLE: begin
                if (xfer && is_open) begin
                    if (op_if.cell_zero) begin
                        skip_cnt_d = SKIP_WIDTH'(1);
                        state_d    = LC_SKIP;
                    end else if (full) begin
                        ovf_d   = 1'b1;
                        state_d = LC_ERROR;
                    end else begin
                        push = 1'b1;
                    end
                end else if (xfer && is_close) begin
                    if (empty) begin
                        unf_d   = 1'b1;
                        state_d = LC_ERROR;
                    end else if (op_if.cell_zero) begin
                        pop = 1'b1;
                    end else begin
                        // Loop back to the instruction after the matching '['; the entry stays pushed.
                        pc_d_d    = top + IA_WIDTH'(1);
                        pc_load_d = 1'b1;
                        state_d   = LC_WAIT_FLUSH;
                    end
                end
            end
            LC_SKIP: begin
                if (xfer && is_open) begin
                    if (&skip_cnt_q) begin
                        ovf_d   = 1'b1;
                        state_d = LC_ERROR;
                    end else begin
                        skip_cnt_d = skip_cnt_q + SKIP_WIDTH'(1);
                    end
                end else if (xfer && is_close) begin
                    skip_cnt_d = skip_cnt_q - SKIP_WIDTH'(1);
                    if (skip_cnt_q == SKIP_WIDTH'(1)) begin
                        state_d = LC_IDLE;
                    end
                end
            end
            LC_WAIT_FLUSH: begin
                if (flush_done) begin
                    state_d = LC_IDLE;
                end
            end
            default: begin
                state_d = LC_ERROR;
            end
        endcase
    end

    assign skip          = (state_q == LC_SKIP);
    assign pc_load       = pc_load_q;
    assign flush         = pc_load_q;
    assign pc_d          = pc_d_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_loop_controller.sv
// tb/tb_loop_controller.sv - directed self-checking bench for loop_controller
module tb_loop_controller;
    logic        clk;
    logic        reset;
    logic        skip, pc_load, flush, flush_done, err_overflow, err_underflow;
    logic [11:0] pc_d;
    logic [4:0]  depth;
    int          checks;
    int          failures;

    loop_controller_if #(.IA_WIDTH(12)) op_if ();

    loop_controller dut (
        .clk           (clk),
        .reset         (reset),
        .op_if         (op_if.slave),
        .skip          (skip),
        .pc_load       (pc_load),
        .pc_d          (pc_d),
        .flush         (flush),
        .flush_done    (flush_done),
        .depth         (depth),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        op_if.op_valid  = 1'b0;
        op_if.op_open   = 1'b0;
        op_if.op_close  = 1'b0;
        op_if.op_pc     = '0;
        op_if.cell_zero = 1'b0;
        flush_done      = 1'b0;
        reset           = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Presents one op for a single edge; on return the outputs reflect that transfer.
    task automatic send(input string tag, input logic o, input logic c, input logic [11:0] pc, input logic z);
        check({tag, "_rdy"}, 32'(op_if.op_ready), 32'd1);
        op_if.op_valid  = 1'b1;
        op_if.op_open   = o;
        op_if.op_close  = c;
        op_if.op_pc     = pc;
        op_if.cell_zero = z;
        @(posedge clk);
        #1;
        op_if.op_valid = 1'b0;
        op_if.op_open  = 1'b0;
        op_if.op_close = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        apply_reset();

        check("rst_depth", 32'(depth), 32'd0);
        check("rst_ready", 32'(op_if.op_ready), 32'd1);
        check("rst_outs", {27'd0, skip, pc_load, flush, err_overflow, err_underflow}, 32'd0);
        check("rst_pc_d", 32'(pc_d), 32'd0);

        // Backward jump with delayed drain
        send("t1_open", 1'b1, 1'b0, 12'h010, 1'b0);
        check("t1_depth1", 32'(depth), 32'd1);
        send("t1_close", 1'b0, 1'b1, 12'h015, 1'b0);
        check("t1_load", {30'd0, pc_load, flush}, 32'd3);
        check("t1_pc_d", 32'(pc_d), 32'h011);
        check("t1_busy", 32'(op_if.op_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_strobe_once", {30'd0, pc_load, flush}, 32'd0);
        check("t1_still_busy", 32'(op_if.op_ready), 32'd0);
        @(posedge clk); #1;
        flush_done = 1'b1;
        @(posedge clk); #1;
        flush_done = 1'b0;
        check("t1_idle", 32'(op_if.op_ready), 32'd1);
        check("t1_depth_kept", 32'(depth), 32'd1);

        // Loop exit pops
        send("t2_close", 1'b0, 1'b1, 12'h015, 1'b1);
        check("t2_depth0", 32'(depth), 32'd0);
        check("t2_no_load", 32'(pc_load), 32'd0);

        // Illegal open+close is a no-op
        send("t2b_both", 1'b1, 1'b1, 12'h020, 1'b0);
        check("t2b_depth", 32'(depth), 32'd0);
        check("t2b_state", {30'd0, skip, op_if.op_ready}, 32'd1);

        // Skip over a zero-valued loop with one nested pair
        send("t3_open", 1'b1, 1'b0, 12'h030, 1'b1);
        check("t3_skip0", {31'd0, skip}, 32'd1);
        check("t3_cnt0", 32'(dut.skip_cnt_q), 32'd1);
        send("t3_plus", 1'b0, 1'b0, 12'h031, 1'b0);
        check("t3_skip1", {31'd0, skip}, 32'd1);
        send("t3_open2", 1'b1, 1'b0, 12'h032, 1'b0);
        check("t3_cnt2", 32'(dut.skip_cnt_q), 32'd2);
        send("t3_minus", 1'b0, 1'b0, 12'h033, 1'b1);
        check("t3_skip3", {31'd0, skip}, 32'd1);
        send("t3_close2", 1'b0, 1'b1, 12'h034, 1'b0);
        check("t3_cnt1", 32'(dut.skip_cnt_q), 32'd1);
        check("t3_skip4", {31'd0, skip}, 32'd1);
        send("t3_dot", 1'b0, 1'b0, 12'h035, 1'b0);
        check("t3_skip5", {31'd0, skip}, 32'd1);
        send("t3_close", 1'b0, 1'b1, 12'h036, 1'b0);
        check("t3_cnt_end", 32'(dut.skip_cnt_q), 32'd0);
        check("t3_skip_end", {31'd0, skip}, 32'd0);
        check("t3_depth", 32'(depth), 32'd0);
        check("t3_no_load", 32'(pc_load), 32'd0);

        // Underflow
        apply_reset();
        send("t5_close", 1'b0, 1'b1, 12'h040, 1'b0);
        check("t5_unf", {30'd0, err_overflow, err_underflow}, 32'd1);
        check("t5_err_state", {30'd0, skip, op_if.op_ready}, 32'd0);
        check("t5_no_load", 32'(pc_load), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("t5_sticky", 32'(err_underflow), 32'd1);

        // Overflow on the 17th push
        apply_reset();
        check("t4_cleared", {30'd0, err_overflow, err_underflow}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            send("t4_push", 1'b1, 1'b0, 12'(12'h100 + i), 1'b0);
        end
        check("t4_depth16", 32'(depth), 32'd16);
        check("t4_no_err", 32'(err_overflow), 32'd0);
        send("t4_push17", 1'b1, 1'b0, 12'h1FF, 1'b0);
        check("t4_ovf", {30'd0, err_overflow, err_underflow}, 32'd2);
        check("t4_ready", 32'(op_if.op_ready), 32'd0);
        check("t4_depth_held", 32'(depth), 32'd16);
        repeat (3) @(posedge clk); #1;
        check("t4_sticky", 32'(err_overflow), 32'd1);

        // Asynchronous reset mid-SKIP and mid-WAIT_FLUSH, then wrap-around jump
        apply_reset();
        send("t6_skip", 1'b1, 1'b0, 12'h050, 1'b1);
        check("t6_in_skip", {31'd0, skip}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_skip_abort", {30'd0, skip, op_if.op_ready}, 32'd1);
        check("t6_skip_cnt", 32'(dut.skip_cnt_q), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        send("t6_push", 1'b1, 1'b0, 12'h060, 1'b0);
        send("t6_jump", 1'b0, 1'b1, 12'h061, 1'b0);
        check("t6_in_wait", {30'd0, pc_load, op_if.op_ready}, 32'd2);
        #2 reset = 1'b0;
        #1;
        check("t6_wait_abort", {28'd0, pc_load, flush, skip, op_if.op_ready}, 32'd1);
        check("t6_pc_d_rst", 32'(pc_d), 32'd0);
        check("t6_depth_rst", 32'(depth), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        send("t6_push_fff", 1'b1, 1'b0, 12'hFFF, 1'b0);
        send("t6_wrap", 1'b0, 1'b1, 12'h002, 1'b0);
        check("t6_wrap_load", {30'd0, pc_load, flush}, 32'd3);
        check("t6_wrap_pc", 32'(pc_d), 32'h000);
        flush_done = 1'b1;
        @(posedge clk); #1;
        flush_done = 1'b0;
        check("t6_wrap_idle", 32'(op_if.op_ready), 32'd1);
        check("t6_wrap_depth", 32'(depth), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
